shift_register_universal: RTL and testbench
===========================================

Name: shift_register_universal

Overview:
- Parametrised successor to the team's 8-bit control-coded register.
- Adds the following over the single-step register:
  - generic WIDTH;
  - arithmetic shift and rotate modes;
  - a multi-cycle shift-by-N sequencer with busy/done handshake;
  - a registered serial output and a zero flag.
- Used as a datapath register inside ALU/serial-link blocks; ctrl is driven by a controller FSM one cycle ahead.

Parameters:
- WIDTH, 8, register width in bits (at least 2).
- SHAMT_WIDTH, 3, width of shamt; shift amounts 0..2^SHAMT_WIDTH-1 (may exceed WIDTH).

Ports:
- clk  input  1  rising-edge clock
- async_nreset  input  1  asynchronous active-low reset
- ctrl  input  4  opcode, sampled on rising clk edge
- shamt  input  SHAMT_WIDTH  shift count for *_N opcodes, sampled with ctrl
- serial_data_input  input  1  bit inserted by serial loads and logical shifts
- parallel_data_input  input  WIDTH  load value
- data_output  output  WIDTH  register contents
- serial_data_output  output  1  registered copy of the last bit shifted/rotated out
- busy  output  1  multi-cycle shift in progress
- done  output  1  one-cycle pulse after a *_N op completes
- zero  output  1  combinational, data_output == 0

Behaviour:
- Reset (async_nreset=0, asynchronous): data_output=0, serial_data_output=0, busy=0, done=0, FSM=IDLE, counter=0. Takes effect immediately, including mid-operation; a shift in progress is discarded.
- Opcodes, single-cycle, each executes at the sampling edge:
  - 0 NONE: hold.
  - 1 CLR: data_output=0.
  - 2 PARALLEL_LOAD: data_output=parallel_data_input.
  - 3 SERIAL_MSB_LOAD: data_output={sdi, d[W-1:1]}.
  - 4 SERIAL_LSB_LOAD: data_output={d[W-2:0], sdi}.
  - 5 SHL: data_output={d[W-2:0], 0}.
  - 6 SHR: data_output={0, d[W-1:1]}.
  - 7 SAR: data_output={d[W-1], d[W-1:1]}.
  - 8 ROL: data_output={d[W-2:0], d[W-1]}.
  - 9 ROR: data_output={d[0], d[W-1:1]}.
- Opcodes, multi-cycle:
  - 10 SHL_N, 11 SHR_N, 12 SAR_N, 13 ROL_N, 14 ROR_N.
  - Each repeats the matching single-step op (5..9) shamt times, one step per clock.
- Opcode 15: treated as NONE.
- serial_data_output update rules:
  - Updated on every edge that shifts or rotates.
  - Takes the bit leaving the register: old d[W-1] for left moves and SERIAL_LSB_LOAD; old d[0] for right moves and SERIAL_MSB_LOAD.
  - Holds otherwise.
  - Cleared by CLR.
- FSM states: IDLE, SHIFT.
- IDLE:
  - ctrl is sampled every edge.
  - *_N with shamt=k>0: the first step is performed at the accepting edge and counter=k-1.
    - If k-1>0: go to SHIFT, busy=1.
    - Else: stay IDLE, done=1 for the next cycle.
  - *_N with shamt=0: no data change, done=1 for the next cycle, busy stays 0.
- SHIFT:
  - ctrl and shamt are ignored, except CLR.
  - Each edge performs one step of the latched op and decrements counter.
  - At the edge where counter goes 1->0: go to IDLE, busy=0, done=1 for exactly one cycle.
  - Total: k shifts in k edges; busy high for k-1 cycles.
- CLR during SHIFT (abort):
  - data_output=0, serial_data_output=0, go to IDLE, busy=0.
  - done is not pulsed.
- done timing: registered, high for exactly one cycle, deasserted at the next edge. A new op may be accepted in the cycle done is high.
- shamt >= WIDTH is legal:
  - logical shifts end at 0;
  - SAR ends at all copies of the sign bit;
  - rotates wrap modulo WIDTH naturally.
- zero: combinational, no added latency.

Test Plan:
- Reset and load: hold async_nreset=0 for 2.5 periods -> data_output=0x00, busy=0, done=0. Then PARALLEL_LOAD 0x0F -> 0x0F after one edge; zero=0.
- Serial loads: from 0x0F, SERIAL_MSB_LOAD sdi=1 -> 0x87, serial_data_output=1. Then SERIAL_LSB_LOAD sdi=0 -> 0x0E, serial_data_output=1.
- Single steps on 0x81:
  - SAR -> 0xC0, serial_data_output=1.
  - SHR on 0x81 -> 0x40.
  - ROL on 0x81 -> 0x03.
  - ROR on 0x81 -> 0xC0.
  - SHL on 0x81 -> 0x02, serial_data_output=1.
- Multi-cycle: load 0x96, ROL_N shamt=3 -> data 0x2D, 0x5A, 0xB4 on successive edges; busy high exactly 2 cycles; done high exactly 1 cycle after the third edge; ctrl=PARALLEL_LOAD during busy is ignored.
- Boundary: SAR_N shamt=7 on 0x80 -> 0xFF, done pulse. SHR_N shamt=0 -> data unchanged, busy never 1, done pulse next cycle.
- Abort and reset mid-op:
  - SHL_N shamt=7 on 0xFF, CLR on the 3rd cycle -> data 0x00, busy=0, no done pulse, zero=1.
  - Repeat with async_nreset pulsed low mid-phase -> immediate 0x00, FSM IDLE.

Source files
------------

// File: rtl/shift_register_universal.sv
// Universal shift register: parallel/serial loads, logical and arithmetic
// shifts, rotates, and a multi-cycle shift-by-N sequencer with busy/done.
module shift_register_universal #(
    parameter int WIDTH       = 8,
    parameter int SHAMT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   async_nreset,
    input  logic [3:0]             ctrl,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic                   serial_data_input,
    input  logic [WIDTH-1:0]       parallel_data_input,
    output logic [WIDTH-1:0]       data_output,
    output logic                   serial_data_output,
    output logic                   busy,
    output logic                   done,
    output logic                   zero
);

    localparam logic [3:0] OP_NONE   = 4'd0;
    localparam logic [3:0] OP_CLR    = 4'd1;
    localparam logic [3:0] OP_PLOAD  = 4'd2;
    localparam logic [3:0] OP_SMSB   = 4'd3;
    localparam logic [3:0] OP_SLSB   = 4'd4;
    localparam logic [3:0] OP_SHL    = 4'd5;
    localparam logic [3:0] OP_SHR    = 4'd6;
    localparam logic [3:0] OP_SAR    = 4'd7;
    localparam logic [3:0] OP_ROL    = 4'd8;
    localparam logic [3:0] OP_ROR    = 4'd9;
    localparam logic [3:0] OP_SHL_N  = 4'd10;
    localparam logic [3:0] OP_ROR_N  = 4'd14;
    // Offset from a *_N opcode to its single-step counterpart.
    localparam logic [3:0] N_TO_STEP = 4'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state, next_state;
    logic [SHAMT_WIDTH-1:0] count, next_count;
    logic [3:0]             op_latched, next_op;
    logic [WIDTH-1:0]       next_data;
    logic                   next_sdo;
    logic                   next_done;

    // One shift/rotate step; returns {bit leaving the register, new value}.
    function automatic logic [WIDTH:0] step_once(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] d);
        logic [WIDTH:0] r;
        case (op)
            OP_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {d[0], 1'b0, d[WIDTH-1:1]};
            OP_SAR:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

    // State, counter, latched op and output registers.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state              <= IDLE;
            count              <= '0;
            op_latched         <= OP_NONE;
            data_output        <= '0;
            serial_data_output <= 1'b0;
            done               <= 1'b0;
        end else begin
            state              <= next_state;
            count              <= next_count;
            op_latched         <= next_op;
            data_output        <= next_data;
            serial_data_output <= next_sdo;
            done               <= next_done;
        end
    end

    // Opcode decode, step sequencing and abort handling.
    always_comb begin
        logic [WIDTH:0] stepped;
        next_state = state;
        next_count = count;
        next_op    = op_latched;
        next_data  = data_output;
        next_sdo   = serial_data_output;
        next_done  = 1'b0;
        stepped    = '0;

        case (state)
            IDLE: begin
                case (ctrl)
                    OP_CLR: begin
                        next_data = '0;
                        next_sdo  = 1'b0;
                    end
                    OP_PLOAD: next_data = parallel_data_input;
                    OP_SMSB: begin
                        next_data = {serial_data_input, data_output[WIDTH-1:1]};
                        next_sdo  = data_output[0];
                    end
                    OP_SLSB: begin
                        next_data = {data_output[WIDTH-2:0], serial_data_input};
                        next_sdo  = data_output[WIDTH-1];
                    end
                    OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
                        stepped   = step_once(ctrl, data_output);
                        next_data = stepped[WIDTH-1:0];
                        next_sdo  = stepped[WIDTH];
                    end
                    default: begin
                        if (ctrl >= OP_SHL_N && ctrl <= OP_ROR_N) begin
                            if (shamt == '0) begin
                                // Zero-length request completes immediately.
                                next_done = 1'b1;
                            end else begin
                                // First step happens on the accepting edge.
                                stepped    = step_once(ctrl - N_TO_STEP, data_output);
                                next_data  = stepped[WIDTH-1:0];
                                next_sdo   = stepped[WIDTH];
                                next_count = shamt - 1'b1;
                                next_op    = ctrl - N_TO_STEP;
                                if (shamt == 1)
                                    next_done = 1'b1;
                                else
                                    next_state = SHIFT;
                            end
                        end
                    end
                endcase
            end
            SHIFT: begin
                if (ctrl == OP_CLR) begin
                    // Abort: discard the remaining steps without a done pulse.
                    next_data  = '0;
                    next_sdo   = 1'b0;
                    next_count = '0;
                    next_state = IDLE;
                end else begin
                    stepped    = step_once(op_latched, data_output);
                    next_data  = stepped[WIDTH-1:0];
                    next_sdo   = stepped[WIDTH];
                    next_count = count - 1'b1;
                    if (count == 1) begin
                        next_state = IDLE;
                        next_done  = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign zero = (data_output == '0);

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal: directed vector table, hand-written
// multi-cycle/abort/reset sequences, then randomized transactions against
// an arithmetic reference model.
module tb_shift_register_universal;

    logic       clk;
    logic       async_nreset;
    logic [3:0] ctrl;
    logic [2:0] shamt;
    logic       sdi;
    logic [7:0] pdata;
    logic [7:0] data_output;
    logic       serial_data_output;
    logic       busy;
    logic       done;
    logic       zero;

    int tests = 0;
    int fails = 0;

    shift_register_universal #(.WIDTH(8), .SHAMT_WIDTH(3)) dut (
        .clk                 (clk),
        .async_nreset        (async_nreset),
        .ctrl                (ctrl),
        .shamt               (shamt),
        .serial_data_input   (sdi),
        .parallel_data_input (pdata),
        .data_output         (data_output),
        .serial_data_output  (serial_data_output),
        .busy                (busy),
        .done                (done),
        .zero                (zero)
    );

    // Posedges at 10, 20, 30 ... so a 25 ns reset release falls mid-cycle.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] c;
        logic       s;
        logic [7:0] p;
        logic [7:0] exp_data;
        logic       exp_sdo;
    } vec_t;

    vec_t vecs [24];

    // Reference: single step of ops 5..9 on an 8-bit value using arithmetic.
    function automatic int mstep(input int op, input int d);
        case (op)
            5: return (d * 2) % 256;
            6: return d / 2;
            7: return d / 2 + ((d >= 128) ? 128 : 0);
            8: return (d * 2) % 256 + d / 128;
            9: return d / 2 + (d % 2) * 128;
            default: return d;
        endcase
    endfunction

    function automatic int mout(input int op, input int d);
        return (op == 5 || op == 8) ? d / 128 : d % 2;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ed, input int esdo,
                             input int ebusy, input int edone);
        check({tag, ".data"}, int'(data_output), ed);
        check({tag, ".sdo"},  int'(serial_data_output), esdo);
        check({tag, ".busy"}, int'(busy), ebusy);
        check({tag, ".done"}, int'(done), edone);
        check({tag, ".zero"}, int'(zero), (ed == 0) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int mdata, msdo;

    initial begin
        vecs[0]  = '{4'd2,  1'b0, 8'h0F, 8'h0F, 1'b0};
        vecs[1]  = '{4'd3,  1'b1, 8'h00, 8'h87, 1'b1};
        vecs[2]  = '{4'd4,  1'b0, 8'h00, 8'h0E, 1'b1};
        vecs[3]  = '{4'd2,  1'b0, 8'h81, 8'h81, 1'b1};
        vecs[4]  = '{4'd7,  1'b0, 8'h00, 8'hC0, 1'b1};
        vecs[5]  = '{4'd2,  1'b0, 8'h81, 8'h81, 1'b1};
        vecs[6]  = '{4'd6,  1'b0, 8'h00, 8'h40, 1'b1};
        vecs[7]  = '{4'd2,  1'b0, 8'h81, 8'h81, 1'b1};
        vecs[8]  = '{4'd8,  1'b0, 8'h00, 8'h03, 1'b1};
        vecs[9]  = '{4'd2,  1'b0, 8'h81, 8'h81, 1'b1};
        vecs[10] = '{4'd9,  1'b0, 8'h00, 8'hC0, 1'b1};
        vecs[11] = '{4'd2,  1'b0, 8'h81, 8'h81, 1'b1};
        vecs[12] = '{4'd5,  1'b0, 8'h00, 8'h02, 1'b1};
        vecs[13] = '{4'd1,  1'b0, 8'h00, 8'h00, 1'b0};
        vecs[14] = '{4'd0,  1'b1, 8'hFF, 8'h00, 1'b0};
        vecs[15] = '{4'd15, 1'b1, 8'hFF, 8'h00, 1'b0};
        vecs[16] = '{4'd2,  1'b0, 8'h40, 8'h40, 1'b0};
        vecs[17] = '{4'd5,  1'b1, 8'h00, 8'h80, 1'b0};
        vecs[18] = '{4'd5,  1'b1, 8'h00, 8'h00, 1'b1};
        vecs[19] = '{4'd3,  1'b0, 8'h00, 8'h00, 1'b0};
        vecs[20] = '{4'd4,  1'b1, 8'h00, 8'h01, 1'b0};
        vecs[21] = '{4'd7,  1'b0, 8'h00, 8'h00, 1'b1};
        vecs[22] = '{4'd2,  1'b0, 8'h80, 8'h80, 1'b1};
        vecs[23] = '{4'd7,  1'b0, 8'h00, 8'hC0, 1'b0};

        async_nreset = 1'b0;
        ctrl  = 4'd0;
        shamt = 3'd0;
        sdi   = 1'b0;
        pdata = 8'h00;

        // Reset held for 2.5 periods.
        #25;
        check_all("reset", 0, 0, 0, 0);
        async_nreset = 1'b1;

        // Directed single-cycle vectors.
        for (int i = 0; i < 24; i++) begin
            ctrl  = vecs[i].c;
            sdi   = vecs[i].s;
            pdata = vecs[i].p;
            tick();
            check_all($sformatf("vec%0d", i), int'(vecs[i].exp_data),
                      int'(vecs[i].exp_sdo), 0, 0);
        end

        // ROL_N by 3 on 0x96, loads during busy are ignored.
        ctrl = 4'd2; pdata = 8'h96; tick();
        ctrl = 4'd13; shamt = 3'd3; tick();
        check_all("roln.e1", 8'h2D, 1, 1, 0);
        ctrl = 4'd2; pdata = 8'h00; tick();
        check_all("roln.e2", 8'h5A, 0, 1, 0);
        tick();
        check_all("roln.e3", 8'hB4, 0, 0, 1);
        ctrl = 4'd0; tick();
        check_all("roln.after", 8'hB4, 0, 0, 0);

        // SAR_N by 7 on 0x80 fills with the sign bit.
        begin
            int edges, busy_cycles;
            ctrl = 4'd2; pdata = 8'h80; tick();
            ctrl = 4'd12; shamt = 3'd7; tick();
            ctrl = 4'd0;
            edges = 1;
            busy_cycles = busy ? 1 : 0;
            while (!done && edges < 20) begin
                tick();
                edges++;
                if (busy) busy_cycles++;
            end
            check("sarn.edges", edges, 7);
            check("sarn.busy_cycles", busy_cycles, 6);
            check_all("sarn.end", 8'hFF, 0, 0, 1);
            tick();
            check("sarn.done_clear", int'(done), 0);
        end

        // SHR_N with shamt 0: no change, immediate done, never busy.
        ctrl = 4'd11; shamt = 3'd0; tick();
        check_all("shrn0", 8'hFF, 0, 0, 1);
        ctrl = 4'd0; tick();
        check_all("shrn0.after", 8'hFF, 0, 0, 0);

        // SHL_N by 7 on 0xFF aborted by CLR on the third edge.
        ctrl = 4'd2; pdata = 8'hFF; tick();
        ctrl = 4'd10; shamt = 3'd7; tick();
        check_all("abort.e1", 8'hFE, 1, 1, 0);
        ctrl = 4'd0; tick();
        check_all("abort.e2", 8'hFC, 1, 1, 0);
        ctrl = 4'd1; tick();
        check_all("abort.clr", 0, 0, 0, 0);
        ctrl = 4'd0; tick();
        check_all("abort.after", 0, 0, 0, 0);

        // Same op interrupted by an asynchronous reset pulse mid-cycle.
        ctrl = 4'd2; pdata = 8'hFF; tick();
        ctrl = 4'd10; shamt = 3'd7; tick();
        ctrl = 4'd0; tick();
        check_all("rstmid.pre", 8'hFC, 1, 1, 0);
        #3 async_nreset = 1'b0;
        #1 check_all("rstmid.async", 0, 0, 0, 0);
        #2 async_nreset = 1'b1;
        tick();
        check_all("rstmid.after", 0, 0, 0, 0);

        // Randomized transactions against the reference model.
        mdata = 0;
        msdo  = 0;
        for (int t = 0; t < 150; t++) begin
            int op, k, abort_at, ebusy, edone;
            op    = int'($urandom_range(0, 15));
            k     = int'($urandom_range(0, 7));
            ctrl  = 4'(op);
            shamt = 3'(k);
            sdi   = 1'($urandom_range(0, 1));
            pdata = 8'($urandom_range(0, 255));
            if (op >= 10 && op <= 14) begin
                if (k == 0) begin
                    tick();
                    check_all($sformatf("rnd%0d.n0", t), mdata, msdo, 0, 1);
                end else begin
                    abort_at = (k >= 2 && $urandom_range(0, 5) == 0)
                               ? int'($urandom_range(2, k)) : 0;
                    for (int i = 1; i <= k; i++) begin
                        if (i > 1) begin
                            int f;
                            f = int'($urandom_range(0, 15));
                            if (f == 1) f = 0;
                            ctrl  = (i == abort_at) ? 4'd1 : 4'(f);
                            shamt = 3'($urandom_range(0, 7));
                            sdi   = 1'($urandom_range(0, 1));
                            pdata = 8'($urandom_range(0, 255));
                        end
                        tick();
                        if (i == abort_at) begin
                            mdata = 0;
                            msdo  = 0;
                            check_all($sformatf("rnd%0d.abort", t), mdata, msdo, 0, 0);
                            break;
                        end
                        msdo  = mout(op - 5, mdata);
                        mdata = mstep(op - 5, mdata);
                        ebusy = (i < k) ? 1 : 0;
                        edone = (i == k) ? 1 : 0;
                        check_all($sformatf("rnd%0d.s%0d", t, i), mdata, msdo, ebusy, edone);
                    end
                end
            end else begin
                tick();
                case (op)
                    1: begin mdata = 0; msdo = 0; end
                    2: mdata = int'(pdata);
                    3: begin msdo = mdata % 2; mdata = int'(sdi) * 128 + mdata / 2; end
                    4: begin msdo = mdata / 128; mdata = (mdata * 2) % 256 + int'(sdi); end
                    5, 6, 7, 8, 9: begin msdo = mout(op, mdata); mdata = mstep(op, mdata); end
                    default: ;
                endcase
                check_all($sformatf("rnd%0d.op%0d", t, op), mdata, msdo, 0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
